uart_cmd_parser: RTL and testbench

- Frame-level receive controller placed directly after the UART byte receiver in the smart-car FPGA.
- Consumes the byte stream (data + one-cycle valid), sequences frame reception, checks length and checksum, and enforces an inter-byte timeout.
- Presents each validated command to the motion/control logic over a valid/ready handshake.
- Frame format: 0x55, 0xAA, CMD, LEN, PAYLOAD[LEN], CHK, where CHK = (CMD + LEN + sum of payload bytes) mod 256.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/timeout_cnt.sv | 30 +++
 rtl/uart_cmd_parser.sv | 134 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART command path.
package uart_pkg;

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    localparam logic [1:0] ERR_OVF = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } state_t;

endpackage

// File: rtl/timeout_cnt.sv
// Up-counter that flags expiry at MAX-1; held at zero while disabled or cleared.
module timeout_cnt #(
    parameter int MAX = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (MAX > 2) ? $clog2(MAX) : 1;

    logic [W-1:0] cnt;
    logic         at_tc;

    assign at_tc  = (cnt == W'(MAX - 1));
    assign expire = en && at_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || at_tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame receiver: 55 AA CMD LEN PAYLOAD[LEN] CHK, checksum = CMD+LEN+payload mod 256.
//   state   | meaning
//   IDLE    | hunting for 0x55
//   HDR     | got 0x55, expecting 0xAA (0x55 resyncs)
//   CMD     | expecting command byte
//   LEN     | expecting length byte
//   PAY     | collecting payload bytes
//   CHK     | expecting checksum byte
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TIMEOUT_US = 2000,
    parameter int MAX_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic [3:0]           cmd_len,
    output logic [8*MAX_LEN-1:0] cmd_payload,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;

    state_t               state;
    logic [3:0]           idx;
    logic [3:0]           len_w;
    logic [7:0]           cmd_w;
    logic [7:0]           chk_w;
    logic [8*MAX_LEN-1:0] pay_w;
    logic                 tmo;

    timeout_cnt #(.MAX(TIMEOUT_CYCLES)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid),
        .en     (state != ST_IDLE),
        .expire (tmo)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            len_w       <= '0;
            cmd_w       <= '0;
            chk_w       <= '0;
            pay_w       <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            err_pulse   <= 1'b0;
            err_code    <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            // An arriving byte always takes priority over a coincident timeout.
            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == HDR0) state <= ST_HDR;
                    end
                    ST_HDR: begin
                        if (rx_data == HDR1) begin
                            state <= ST_CMD;
                            pay_w <= '0;
                        end else if (rx_data != HDR0) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_CMD: begin
                        cmd_w <= rx_data;
                        chk_w <= rx_data;
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_data > 8'(MAX_LEN)) begin
                            state     <= ST_IDLE;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_LEN;
                        end else begin
                            len_w <= rx_data[3:0];
                            chk_w <= chk_w + rx_data;
                            idx   <= '0;
                            state <= (rx_data == 8'd0) ? ST_CHK : ST_PAY;
                        end
                    end
                    ST_PAY: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx == 4'(i)) pay_w[8*i +: 8] <= rx_data;
                        end
                        chk_w <= chk_w + rx_data;
                        idx   <= idx + 4'd1;
                        if (idx + 4'd1 == len_w) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        state <= ST_IDLE;
                        if (rx_data != chk_w) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_CHK;
                        end else if (!cmd_valid || cmd_ready) begin
                            cmd_valid   <= 1'b1;
                            cmd_code    <= cmd_w;
                            cmd_len     <= len_w;
                            cmd_payload <= pay_w;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_OVF;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (tmo) begin
                state     <= ST_IDLE;
                err_pulse <= 1'b1;
                err_code  <= ERR_TMO;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame vector table plus timeout, overflow and reset sequences.
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 4;
    localparam int TMO     = 50 * 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic [31:0] cmd_payload;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;

    uart_cmd_parser #(
        .CLK_FREQ   (50_000_000),
        .TIMEOUT_US (20),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) err_seen++;

    typedef struct {
        string       name;
        logic [95:0] bytes;
        int          n;
        bit          exp_valid;
        logic [7:0]  exp_code;
        logic [3:0]  exp_len;
        logic [31:0] exp_pay;
        bit          exp_err;
        logic [1:0]  exp_ecode;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [95:0] bb, input int n);
        for (int j = 0; j < n; j++) send_byte(bb[8*j +: 8]);
    endtask

    initial begin
        int  k;
        int  e0;
        bit  got;
        bit  early;
        logic [95:0] bb;

        vecs[0] = '{"good",     96'h33_20_10_02_01_AA_55,       7, 1, 8'h01, 4'd2, 32'h0000_2010, 0, 2'd0};
        vecs[1] = '{"badchk",   96'h34_20_10_02_01_AA_55,       7, 0, 8'h00, 4'd0, 32'h0,         1, 2'd2};
        vecs[2] = '{"badlen",   96'h05_07_AA_55,                4, 0, 8'h00, 4'd0, 32'h0,         1, 2'd1};
        vecs[3] = '{"zerolen",  96'h03_00_03_AA_55,             5, 1, 8'h03, 4'd0, 32'h0,         0, 2'd0};
        vecs[4] = '{"resync",   96'h03_00_03_AA_55_55,          6, 1, 8'h03, 4'd0, 32'h0,         0, 2'd0};
        vecs[5] = '{"maxlen",   96'h10_04_03_02_01_04_02_AA_55, 9, 1, 8'h02, 4'd4, 32'h0403_0201, 0, 2'd0};
        vecs[6] = '{"garbage",  96'h12_55_12,                   3, 0, 8'h00, 4'd0, 32'h0,         0, 2'd0};
        vecs[7] = '{"wrap",     96'h12_30_F0_02_F0_AA_55,       7, 1, 8'hF0, 4'd2, 32'h0000_30F0, 0, 2'd0};
        vecs[8] = '{"len1zero", 96'h0A_FF_01_0A_AA_55,          6, 1, 8'h0A, 4'd1, 32'h0000_00FF, 0, 2'd0};
        vecs[9] = '{"biglen",   96'h14_07_AA_55,                4, 0, 8'h00, 4'd0, 32'h0,         1, 2'd1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_code", 32'(cmd_code), 32'd0);
        chk("rst_pay", cmd_payload, 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            e0 = err_seen;
            bb = vecs[i].bytes;
            send_frame(bb, vecs[i].n);
            chk({vecs[i].name, "_valid"}, 32'(cmd_valid), 32'(vecs[i].exp_valid));
            chk({vecs[i].name, "_err"}, 32'(err_pulse), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) chk({vecs[i].name, "_ecode"}, 32'(err_code), 32'(vecs[i].exp_ecode));
            if (vecs[i].exp_valid) begin
                chk({vecs[i].name, "_code"}, 32'(cmd_code), 32'(vecs[i].exp_code));
                chk({vecs[i].name, "_len"}, 32'(cmd_len), 32'(vecs[i].exp_len));
                chk({vecs[i].name, "_pay"}, cmd_payload, vecs[i].exp_pay);
            end
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_valid_drop"}, 32'(cmd_valid), 32'd0);
            chk({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
            chk({vecs[i].name, "_errcount"}, 32'(err_seen - e0), 32'(vecs[i].exp_err));
        end

        // Timeout fires exactly TMO cycles after the last byte.
        send_frame(96'h01_AA_55, 3);
        k = 0;
        got = 0;
        while (k < TMO + 5 && !got) begin
            @(posedge clk);
            #1;
            k++;
            if (err_pulse) got = 1;
        end
        chk("tmo_cycle", 32'(k), 32'(TMO));
        chk("tmo_ecode", 32'(err_code), 32'd3);
        chk("tmo_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Byte landing on the terminal-count cycle wins over the timeout.
        e0 = err_seen;
        send_frame(96'h01_AA_55, 3);
        early = 0;
        repeat (TMO - 1) begin
            @(posedge clk);
            #1;
            if (err_pulse) early = 1;
        end
        chk("tc_early_err", 32'(early), 32'd0);
        send_byte(8'h02);
        chk("tc_byte_err", 32'(err_pulse), 32'd0);
        chk("tc_byte_busy", 32'(busy), 32'd1);
        send_frame(96'h33_20_10, 3);
        chk("tc_valid", 32'(cmd_valid), 32'd1);
        chk("tc_code", 32'(cmd_code), 32'h01);
        chk("tc_pay", cmd_payload, 32'h0000_2010);
        chk("tc_errcount", 32'(err_seen - e0), 32'd0);
        @(posedge clk);
        #1;

        // Overflow: second good frame dropped while the first is pending.
        cmd_ready = 1'b0;
        send_frame(96'h03_00_03_AA_55, 5);
        chk("ovf_first_valid", 32'(cmd_valid), 32'd1);
        send_frame(96'h33_20_10_02_01_AA_55, 7);
        chk("ovf_err", 32'(err_pulse), 32'd1);
        chk("ovf_ecode", 32'(err_code), 32'd0);
        chk("ovf_valid", 32'(cmd_valid), 32'd1);
        chk("ovf_code", 32'(cmd_code), 32'h03);
        chk("ovf_len", 32'(cmd_len), 32'd0);
        chk("ovf_pay", cmd_payload, 32'd0);
        @(posedge clk);
        #1;
        chk("ovf_hold", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_release", 32'(cmd_valid), 32'd0);

        // Accept and reload in the same cycle keeps cmd_valid high with new data.
        cmd_ready = 1'b0;
        send_frame(96'h03_00_03_AA_55, 5);
        send_frame(96'h20_10_02_01_AA_55, 6);
        cmd_ready = 1'b1;
        send_byte(8'h33);
        chk("reload_valid", 32'(cmd_valid), 32'd1);
        chk("reload_err", 32'(err_pulse), 32'd0);
        chk("reload_code", 32'(cmd_code), 32'h01);
        chk("reload_len", 32'(cmd_len), 32'd2);
        chk("reload_pay", cmd_payload, 32'h0000_2010);
        @(posedge clk);
        #1;
        chk("reload_drop", 32'(cmd_valid), 32'd0);

        // Reset mid-frame with a command pending.
        cmd_ready = 1'b0;
        send_frame(96'h0A_FF_01_0A_AA_55, 6);
        send_frame(96'h02_01_AA_55, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(cmd_valid), 32'd0);
        chk("mrst_code", 32'(cmd_code), 32'd0);
        chk("mrst_len", 32'(cmd_len), 32'd0);
        chk("mrst_pay", cmd_payload, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'(err_pulse), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        e0 = err_seen;
        send_frame(96'h33_20_10_02_01_AA_55, 7);
        chk("post_valid", 32'(cmd_valid), 32'd1);
        chk("post_code", 32'(cmd_code), 32'h01);
        chk("post_pay", cmd_payload, 32'h0000_2010);
        @(posedge clk);
        #1;
        chk("post_errcount", 32'(err_seen - e0), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
